uart_prog_ctrl: RTL and testbench

Sequencer for UART program download into instruction and data memory. It holds the CPU, releases the UART programmer from reset, and steers each received word to the instruction-memory or data-memory write port. It then forces a PC restart at address 0 once loading completes. It sits between the UART programmer IP and the IFetch/DataMem upg write ports, and replaces the ad-hoc upg_rst/wen gating in the top level.

---
 rtl/uart_prog_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_prog_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_ctrl.sv
// rtl/uart_prog_ctrl.sv - UART program-download sequencer steering words into imem/dmem
// Holds the CPU during download and pulses a PC restart once the transfer completes.
module uart_prog_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             upg_wen_i,
  input  logic [14:0]      upg_adr_i,
  input  logic [31:0]      upg_dat_i,
  input  logic             upg_done_i,
  output logic             upg_rst_o,
  output logic             cpu_hold_o,
  output logic             imem_wen_o,
  output logic             dmem_wen_o,
  output logic [13:0]      mem_adr_o,
  output logic [31:0]      mem_dat_o,
  output logic             pc_reset_o,
  output logic [CNT_W-1:0] imem_cnt_o,
  output logic [CNT_W-1:0] dmem_cnt_o,
  output logic [1:0]       status_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RELEASE,
    ST_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nxt;
  logic        wen_prev;
  logic [31:0] tmo_cnt;
  logic        rise;
  logic        timeout;
  logic        start;

  // The edge register only tracks the strobe while loading, so a strobe already
  // high when LOAD is entered still counts as a fresh word.
  assign rise    = (state == ST_LOAD) && upg_wen_i && !wen_prev;
  assign timeout = !rise && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    upg_rst_o  = 1'b1;
    cpu_hold_o = 1'b1;
    pc_reset_o = 1'b0;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_hold_o = 1'b0;
        if (req_i) begin
          state_nxt = ST_LOAD;
          start     = 1'b1;
        end
      end
      ST_LOAD: begin
        upg_rst_o = 1'b0;
        if (upg_done_i)   state_nxt = ST_FLUSH;
        else if (timeout) state_nxt = ST_ERROR;
      end
      ST_FLUSH:   state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        pc_reset_o = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_ERROR: begin
        if (req_i) begin
          state_nxt = ST_LOAD;
          start     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wen_prev   <= 1'b0;
      tmo_cnt    <= 32'd0;
      imem_wen_o <= 1'b0;
      dmem_wen_o <= 1'b0;
      mem_adr_o  <= 14'd0;
      mem_dat_o  <= 32'd0;
      imem_cnt_o <= '0;
      dmem_cnt_o <= '0;
      status_o   <= 2'd0;
    end else begin
      imem_wen_o <= 1'b0;
      dmem_wen_o <= 1'b0;
      wen_prev   <= (state == ST_LOAD) && upg_wen_i;

      if (start) begin
        tmo_cnt    <= 32'd0;
        imem_cnt_o <= '0;
        dmem_cnt_o <= '0;
        status_o   <= 2'd1;
      end else if (state == ST_LOAD) begin
        tmo_cnt <= rise ? 32'd0 : tmo_cnt + 32'd1;
      end

      if (rise) begin
        mem_adr_o <= upg_adr_i[13:0];
        mem_dat_o <= upg_dat_i;
        if (upg_adr_i[14]) begin
          dmem_wen_o <= 1'b1;
          if (dmem_cnt_o != '1) dmem_cnt_o <= dmem_cnt_o + CNT_ONE;
        end else begin
          imem_wen_o <= 1'b1;
          if (imem_cnt_o != '1) imem_cnt_o <= imem_cnt_o + CNT_ONE;
        end
      end

      if (state == ST_LOAD && state_nxt == ST_ERROR) status_o <= 2'd3;
      if (state == ST_RELEASE)                       status_o <= 2'd2;
    end
  end

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// tb/tb_uart_prog_ctrl.sv - self-checking bench for uart_prog_ctrl
// Directed scenarios plus random traffic, all checked cycle by cycle against a session model.
module tb_uart_prog_ctrl;

  localparam int T   = 20;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_RELEASE = 3, M_ERROR = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          upg_wen_i = 1'b0;
  logic [14:0]   upg_adr_i = '0;
  logic [31:0]   upg_dat_i = '0;
  logic          upg_done_i = 1'b0;
  logic          upg_rst_o, cpu_hold_o, imem_wen_o, dmem_wen_o, pc_reset_o;
  logic [13:0]   mem_adr_o;
  logic [31:0]   mem_dat_o;
  logic [CW-1:0] imem_cnt_o, dmem_cnt_o;
  logic [1:0]    status_o;

  always #5 clk = ~clk;

  uart_prog_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .upg_wen_i(upg_wen_i),
    .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i),
    .upg_rst_o(upg_rst_o), .cpu_hold_o(cpu_hold_o), .imem_wen_o(imem_wen_o),
    .dmem_wen_o(dmem_wen_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .pc_reset_o(pc_reset_o), .imem_cnt_o(imem_cnt_o), .dmem_cnt_o(dmem_cnt_o),
    .status_o(status_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Session model: cycle number of the last activity drives the timeout rule.
  int          cyc = 0;
  int          last_act = 0;
  int          m_mode = M_IDLE;
  bit          m_prev = 0;
  int          m_icnt = 0, m_dcnt = 0, m_status = 0;
  bit          m_iw = 0, m_dw = 0;
  logic [13:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  int          pc_pulses = 0;

  task automatic step(input bit rs, input bit rq, input bit w, input bit dn,
                      input logic [14:0] a, input logic [31:0] d);
    bit rise;
    rst_i = rs; req_i = rq; upg_wen_i = w; upg_done_i = dn; upg_adr_i = a; upg_dat_i = d;
    if (rs) begin
      m_mode = M_IDLE; m_prev = 0; m_icnt = 0; m_dcnt = 0; m_status = 0;
      m_iw = 0; m_dw = 0; m_adr = '0; m_dat = '0;
    end else begin
      rise = (m_mode == M_LOAD) && w && !m_prev;
      m_prev = (m_mode == M_LOAD) && w;
      m_iw = 0; m_dw = 0;
      if (rise) begin
        last_act = cyc;
        m_adr = a[13:0];
        m_dat = d;
        if (a[14]) begin m_dw = 1; m_dcnt = (m_dcnt < SAT) ? m_dcnt + 1 : SAT; end
        else       begin m_iw = 1; m_icnt = (m_icnt < SAT) ? m_icnt + 1 : SAT; end
      end
      case (m_mode)
        M_IDLE, M_ERROR:
          if (rq) begin m_mode = M_LOAD; m_icnt = 0; m_dcnt = 0; m_status = 1; last_act = cyc; end
        M_LOAD:
          if (dn) m_mode = M_FLUSH;
          else if (!rise && cyc - last_act >= T) begin m_mode = M_ERROR; m_status = 3; end
        M_FLUSH:   m_mode = M_RELEASE;
        M_RELEASE: begin m_mode = M_IDLE; m_status = 2; end
        default:   m_mode = M_IDLE;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (pc_reset_o === 1'b1) pc_pulses++;
    check("upg_rst",  64'(upg_rst_o),  64'(m_mode != M_LOAD));
    check("cpu_hold", 64'(cpu_hold_o), 64'(m_mode != M_IDLE));
    check("pc_reset", 64'(pc_reset_o), 64'(m_mode == M_RELEASE));
    check("imem_wen", 64'(imem_wen_o), 64'(m_iw));
    check("dmem_wen", 64'(dmem_wen_o), 64'(m_dw));
    check("mem_adr",  64'(mem_adr_o),  64'(m_adr));
    check("mem_dat",  64'(mem_dat_o),  64'(m_dat));
    check("imem_cnt", 64'(imem_cnt_o), 64'(m_icnt));
    check("dmem_cnt", 64'(dmem_cnt_o), 64'(m_dcnt));
    check("status",   64'(status_o),   64'(m_status));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 15'h0, 32'h0);
  endtask

  initial begin
    bit          w;
    bit          quiet;
    logic [14:0] ra;
    logic [31:0] rd;

    step(1, 0, 0, 0, 15'h0, 32'h0);
    step(1, 0, 0, 0, 15'h0, 32'h0);
    check("rst_upg_rst", 64'(upg_rst_o), 64'd1);
    check("rst_hold",    64'(cpu_hold_o), 64'd0);
    check("rst_status",  64'(status_o), 64'd0);
    check("rst_adr",     64'(mem_adr_o), 64'd0);

    // Basic load
    step(0, 1, 0, 0, 15'h0, 32'h0);
    check("load_upg_rst", 64'(upg_rst_o), 64'd0);
    step(0, 0, 1, 0, 15'h0000, 32'h2008_0001);
    check("w0_imem", 64'(imem_wen_o), 64'd1);
    step(0, 0, 0, 0, 15'h0, 32'h0);
    step(0, 0, 1, 0, 15'h0001, 32'h2009_0002);
    step(0, 0, 0, 0, 15'h0, 32'h0);
    step(0, 0, 1, 0, 15'h4000, 32'hDEAD_BEEF);
    check("w2_dmem", 64'(dmem_wen_o), 64'd1);
    check("w2_adr",  64'(mem_adr_o), 64'd0);
    check("w2_dat",  64'(mem_dat_o), 64'hDEAD_BEEF);
    step(0, 0, 0, 0, 15'h0, 32'h0);
    pc_pulses = 0;
    step(0, 0, 0, 1, 15'h0, 32'h0);
    idle(3);
    check("basic_pc_pulses", 64'(pc_pulses), 64'd1);
    check("basic_status",    64'(status_o), 64'd2);
    check("basic_icnt",      64'(imem_cnt_o), 64'd2);
    check("basic_dcnt",      64'(dmem_cnt_o), 64'd1);

    // Long strobe
    step(0, 1, 0, 0, 15'h0, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 15'h0003, 32'h0000_0033);
    step(0, 0, 0, 0, 15'h0, 32'h0);
    check("long_icnt", 64'(imem_cnt_o), 64'd1);
    step(0, 0, 0, 1, 15'h0, 32'h0);
    idle(3);

    // Timeout, then retry
    step(0, 1, 0, 0, 15'h0, 32'h0);
    step(0, 0, 1, 0, 15'h0007, 32'h7);
    idle(T - 1);
    check("tmo_not_yet", 64'(status_o), 64'd1);
    idle(1);
    check("tmo_status", 64'(status_o), 64'd3);
    check("tmo_upg_rst", 64'(upg_rst_o), 64'd1);
    check("tmo_hold", 64'(cpu_hold_o), 64'd1);
    idle(4);
    check("err_sticky", 64'(status_o), 64'd3);
    step(0, 1, 0, 0, 15'h0, 32'h0);
    check("retry_status", 64'(status_o), 64'd1);
    check("retry_icnt", 64'(imem_cnt_o), 64'd0);

    // Done coincident with the last edge
    step(0, 0, 1, 1, 15'h0005, 32'h1234_5678);
    check("coinc_imem", 64'(imem_wen_o), 64'd1);
    check("coinc_adr",  64'(mem_adr_o), 64'd5);
    check("coinc_icnt", 64'(imem_cnt_o), 64'd1);
    check("coinc_pc_t1", 64'(pc_reset_o), 64'd0);
    step(0, 0, 0, 0, 15'h0, 32'h0);
    check("coinc_pc_t2", 64'(pc_reset_o), 64'd1);
    idle(2);

    // Reset coincident with an edge
    step(0, 1, 0, 0, 15'h0, 32'h0);
    pc_pulses = 0;
    step(1, 0, 1, 0, 15'h0009, 32'h9);
    check("rstw_imem", 64'(imem_wen_o), 64'd0);
    check("rstw_upg_rst", 64'(upg_rst_o), 64'd1);
    check("rstw_status", 64'(status_o), 64'd0);
    idle(3);
    check("rstw_no_pc", 64'(pc_pulses), 64'd0);

    // Counter saturation
    step(0, 1, 0, 0, 15'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 15'(i), 32'(i));
      step(0, 0, 0, 0, 15'h0, 32'h0);
    end
    check("sat_icnt", 64'(imem_cnt_o), 64'd3);
    step(0, 0, 0, 1, 15'h0, 32'h0);
    idle(3);

    // Random traffic
    w = 0;
    for (int i = 0; i < 3000; i++) begin
      quiet = (i % 300) > 260;
      if (!quiet && $urandom_range(0, 9) < 3) w = ~w;
      ra = 15'($urandom);
      rd = $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 14) == 0, w,
           !quiet && $urandom_range(0, 39) == 0, ra, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
